// File: rtl/pwm_update_ctrl.sv
// Shadow/active configuration controller for one PWM channel: host writes land in shadow
// registers and are copied (sanitised) to the active outputs only at safe points.
module pwm_update_ctrl #(
  parameter int W          = 16,
  parameter int MIN_PERIOD = 4
) (
  input  logic         MClk,
  input  logic         RstN,
  input  logic         CfgValid,
  output logic         CfgReady,
  input  logic [1:0]   CfgAddr,
  input  logic [W-1:0] CfgData,
  input  logic         Enable,
  input  logic         PeriodEnd,
  input  logic         Fault,
  input  logic         FaultClr,
  output logic [W-1:0] PeriodCount,
  output logic [W-1:0] DutyCount,
  output logic [W-1:0] DeadTimeCount,
  output logic         OutEn,
  output logic         Committed,
  output logic         FaultLatched,
  output logic         Busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [W-1:0] MIN_P = W'(MIN_PERIOD);

  state_t       r_state;
  logic [W-1:0] r_sh_period, r_sh_duty, r_sh_dead;
  logic [W-1:0] r_act_period, r_act_duty, r_act_dead;
  logic         r_busy, r_ready, r_out_en, r_committed, r_fault_latched;

  state_t       w_state_nxt;
  logic [W-1:0] w_sh_period_nxt, w_sh_duty_nxt, w_sh_dead_nxt;
  logic [W-1:0] w_act_period_nxt, w_act_duty_nxt, w_act_dead_nxt;
  logic [W-1:0] w_san_period, w_san_duty, w_san_dead, w_half_period;
  logic         w_busy_nxt, w_ready_nxt, w_load, w_commit, w_wr, w_commit_req;

  // Sanitised view of the shadow set; every copy to active goes through this.
  assign w_san_period  = (r_sh_period < MIN_P) ? MIN_P : r_sh_period;
  assign w_half_period = w_san_period >> 1;
  assign w_san_duty    = (r_sh_duty > w_san_period) ? w_san_period : r_sh_duty;
  assign w_san_dead    = (r_sh_dead > w_half_period) ? w_half_period : r_sh_dead;

  // Fault takes priority over everything, including a write presented on the same edge.
  assign w_wr         = CfgValid & r_ready & ~Fault;
  assign w_commit_req = w_wr & (CfgAddr == 2'd3);

  always_comb begin
    w_state_nxt     = r_state;
    w_sh_period_nxt = r_sh_period;
    w_sh_duty_nxt   = r_sh_duty;
    w_sh_dead_nxt   = r_sh_dead;
    w_busy_nxt      = r_busy;
    w_load          = 1'b0;
    w_commit        = 1'b0;

    if (Fault) begin
      w_state_nxt = ST_FAULT;
    end else begin
      if (w_wr) begin
        case (CfgAddr)
          2'd0:    w_sh_period_nxt = CfgData;
          2'd1:    w_sh_duty_nxt   = CfgData;
          2'd2:    w_sh_dead_nxt   = CfgData;
          default: w_busy_nxt      = 1'b1;
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (Enable) begin
            // Enable load consumes any earlier pending commit silently.
            w_state_nxt = ST_RUN;
            w_load      = 1'b1;
            w_busy_nxt  = w_commit_req;
          end else if (r_busy) begin
            w_load     = 1'b1;
            w_commit   = 1'b1;
            w_busy_nxt = 1'b0;
          end
        end
        ST_RUN: begin
          if (!Enable) begin
            w_state_nxt = ST_IDLE;
          end else if (r_busy && PeriodEnd) begin
            w_load     = 1'b1;
            w_commit   = 1'b1;
            w_busy_nxt = 1'b0;
          end
        end
        ST_FAULT: begin
          if (FaultClr) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_act_period_nxt = w_load ? w_san_period : r_act_period;
    w_act_duty_nxt   = w_load ? w_san_duty   : r_act_duty;
    w_act_dead_nxt   = w_load ? w_san_dead   : r_act_dead;
    w_ready_nxt      = ~w_busy_nxt & (w_state_nxt != ST_FAULT);
  end

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      r_state         <= ST_IDLE;
      r_sh_period     <= '0;
      r_sh_duty       <= '0;
      r_sh_dead       <= '0;
      r_act_period    <= '0;
      r_act_duty      <= '0;
      r_act_dead      <= '0;
      r_busy          <= 1'b0;
      r_ready         <= 1'b1;
      r_out_en        <= 1'b0;
      r_committed     <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_sh_period     <= w_sh_period_nxt;
      r_sh_duty       <= w_sh_duty_nxt;
      r_sh_dead       <= w_sh_dead_nxt;
      r_act_period    <= w_act_period_nxt;
      r_act_duty      <= w_act_duty_nxt;
      r_act_dead      <= w_act_dead_nxt;
      r_busy          <= w_busy_nxt;
      r_ready         <= w_ready_nxt;
      r_out_en        <= (w_state_nxt == ST_RUN);
      r_committed     <= w_commit;
      r_fault_latched <= (w_state_nxt == ST_FAULT);
    end
  end

  assign CfgReady      = r_ready;
  assign PeriodCount   = r_act_period;
  assign DutyCount     = r_act_duty;
  assign DeadTimeCount = r_act_dead;
  assign OutEn         = r_out_en;
  assign Committed     = r_committed;
  assign FaultLatched  = r_fault_latched;
  assign Busy          = r_busy;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed vector bench for pwm_update_ctrl: per-cycle input/expected-output table plus
// a hand-written wait-for-PeriodEnd sequence.
module tb_pwm_update_ctrl;

  localparam int W = 16;

  logic         MClk = 1'b0;
  logic         RstN, CfgValid, CfgReady, Enable, PeriodEnd, Fault, FaultClr;
  logic [1:0]   CfgAddr;
  logic [W-1:0] CfgData, PeriodCount, DutyCount, DeadTimeCount;
  logic         OutEn, Committed, FaultLatched, Busy;

  always #5 MClk = ~MClk;

  pwm_update_ctrl #(.W(W), .MIN_PERIOD(4)) dut (
    .MClk(MClk), .RstN(RstN), .CfgValid(CfgValid), .CfgReady(CfgReady),
    .CfgAddr(CfgAddr), .CfgData(CfgData), .Enable(Enable), .PeriodEnd(PeriodEnd),
    .Fault(Fault), .FaultClr(FaultClr), .PeriodCount(PeriodCount), .DutyCount(DutyCount),
    .DeadTimeCount(DeadTimeCount), .OutEn(OutEn), .Committed(Committed),
    .FaultLatched(FaultLatched), .Busy(Busy)
  );

  typedef struct packed {
    logic [W-1:0] p, d, t;
    logic oe, cm, fl, bsy, rdy;
  } out_t;

  typedef struct packed {
    logic rst_n, vld;
    logic [1:0] addr;
    logic [W-1:0] data;
    logic en, pe, flt, fclr;
    out_t exp;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_c[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(input int rst_n, vld, addr, data, en, pe, flt, fclr,
                             input int p, d, t, oe, cm, fl, bsy, rdy);
    vec_t r;
    r.rst_n = rst_n[0]; r.vld = vld[0]; r.addr = addr[1:0]; r.data = data[W-1:0];
    r.en = en[0]; r.pe = pe[0]; r.flt = flt[0]; r.fclr = fclr[0];
    r.exp.p = p[W-1:0]; r.exp.d = d[W-1:0]; r.exp.t = t[W-1:0];
    r.exp.oe = oe[0]; r.exp.cm = cm[0]; r.exp.fl = fl[0]; r.exp.bsy = bsy[0]; r.exp.rdy = rdy[0];
    return r;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.p = PeriodCount; o.d = DutyCount; o.t = DeadTimeCount;
    o.oe = OutEn; o.cm = Committed; o.fl = FaultLatched; o.bsy = Busy; o.rdy = CfgReady;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got P=%0d D=%0d T=%0d oe=%0b cm=%0b fl=%0b busy=%0b rdy=%0b, want P=%0d D=%0d T=%0d oe=%0b cm=%0b fl=%0b busy=%0b rdy=%0b",
               name, act.p, act.d, act.t, act.oe, act.cm, act.fl, act.bsy, act.rdy,
               exp.p, exp.d, exp.t, exp.oe, exp.cm, exp.fl, exp.bsy, exp.rdy);
    end
  endtask

  task automatic apply(input vec_t vc, input string name);
    RstN = vc.rst_n; CfgValid = vc.vld; CfgAddr = vc.addr; CfgData = vc.data;
    Enable = vc.en; PeriodEnd = vc.pe; Fault = vc.flt; FaultClr = vc.fclr;
    @(posedge MClk);
    #1;
    check(name, vc.exp);
  endtask

  initial begin
    RstN = 1'b0; CfgValid = 1'b0; CfgAddr = '0; CfgData = '0;
    Enable = 1'b0; PeriodEnd = 1'b0; Fault = 1'b0; FaultClr = 1'b0;

    //               rst vld a  data en pe f fc |  P   D  T oe cm fl bsy rdy
    tbl_a.push_back(v(0, 0, 0,   0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(v(1, 1, 0, 100, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(v(1, 1, 1,  40, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(v(1, 1, 2,   5, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 1));
    tbl_a.push_back(v(1, 0, 0,   0, 1, 0, 0, 0, 100, 40, 5, 1, 0, 0, 0, 1));
    tbl_a.push_back(v(1, 1, 1,  70, 1, 0, 0, 0, 100, 40, 5, 1, 0, 0, 0, 1));
    tbl_a.push_back(v(1, 1, 3,   0, 1, 0, 0, 0, 100, 40, 5, 1, 0, 0, 1, 0));

    // Clamp programming, then commit coinciding with PeriodEnd
    tbl_c.push_back(v(1, 1, 0,   2, 1, 0, 0, 0, 100, 70, 5, 1, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 1, 1,   9, 1, 0, 0, 0, 100, 70, 5, 1, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 1, 2,   3, 1, 0, 0, 0, 100, 70, 5, 1, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 1, 3,   0, 1, 1, 0, 0, 100, 70, 5, 1, 0, 0, 1, 0));
    tbl_c.push_back(v(1, 0, 0,   0, 1, 0, 0, 0, 100, 70, 5, 1, 0, 0, 1, 0));
    tbl_c.push_back(v(1, 0, 0,   0, 1, 1, 0, 0,   4,  4, 2, 1, 1, 0, 0, 1));
    tbl_c.push_back(v(1, 0, 0,   0, 1, 0, 0, 0,   4,  4, 2, 1, 0, 0, 0, 1));
    // Fault on a PeriodEnd edge with a commit pending
    tbl_c.push_back(v(1, 1, 1,   3, 1, 0, 0, 0,   4,  4, 2, 1, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 1, 3,   0, 1, 0, 0, 0,   4,  4, 2, 1, 0, 0, 1, 0));
    tbl_c.push_back(v(1, 0, 0,   0, 1, 1, 1, 0,   4,  4, 2, 0, 0, 1, 1, 0));
    tbl_c.push_back(v(1, 1, 0,  50, 1, 0, 1, 1,   4,  4, 2, 0, 0, 1, 1, 0));
    tbl_c.push_back(v(1, 0, 0,   0, 0, 0, 0, 1,   4,  4, 2, 0, 0, 0, 1, 0));
    tbl_c.push_back(v(1, 0, 0,   0, 0, 0, 0, 0,   4,  3, 2, 0, 1, 0, 0, 1));
    tbl_c.push_back(v(1, 0, 0,   0, 0, 0, 0, 0,   4,  3, 2, 0, 0, 0, 0, 1));
    // Reset while enabled with a commit pending, then restart from zeros
    tbl_c.push_back(v(1, 0, 0,   0, 1, 0, 0, 0,   4,  3, 2, 1, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 1, 0, 200, 1, 0, 0, 0,   4,  3, 2, 1, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 1, 3,   0, 1, 0, 0, 0,   4,  3, 2, 1, 0, 0, 1, 0));
    tbl_c.push_back(v(0, 0, 0,   0, 1, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 0, 0,   0, 1, 0, 0, 0,   4,  0, 0, 1, 0, 0, 0, 1));
    tbl_c.push_back(v(1, 0, 0,   0, 0, 0, 0, 0,   4,  0, 0, 0, 0, 0, 0, 1));

    @(negedge MClk);
    foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("tbl_a[%0d]", i));

    // Commit held pending for 10 cycles until PeriodEnd
    for (int i = 0; i < 10; i++)
      apply(v(1, 0, 0, 0, 1, 0, 0, 0, 100, 40, 5, 1, 0, 0, 1, 0), $sformatf("pending[%0d]", i));
    apply(v(1, 0, 0, 0, 1, 1, 0, 0, 100, 70, 5, 1, 1, 0, 0, 1), "commit_at_pe");
    apply(v(1, 0, 0, 0, 1, 0, 0, 0, 100, 70, 5, 1, 0, 0, 0, 1), "committed_one_cycle");

    foreach (tbl_c[i]) apply(tbl_c[i], $sformatf("tbl_c[%0d]", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
